// File: rtl/spi_xfer_ctrl.sv
// SPI transfer controller: serialises one character onto mosi and captures
// miso on the SCLK edge strobes provided by an external clock generator.
// Handshake: a start is accepted when go=1 in IDLE (no ready signal; go is
// simply ignored while busy). Completion is a single-cycle done pulse with
// rx_data valid in that same cycle and held afterwards.
module spi_xfer_ctrl #(
  parameter int MAX_LEN = 32
) (
  input  logic               wb_clk,
  input  logic               wb_reset,
  input  logic               go,
  input  logic [4:0]         char_len,
  input  logic [MAX_LEN-1:0] tx_data,
  input  logic               lsb,
  input  logic               tx_negedge,
  input  logic               rx_negedge,
  input  logic               pos_edge,
  input  logic               neg_edge,
  input  logic               miso,
  output logic               mosi,
  output logic               tip,
  output logic               lstclk,
  output logic [MAX_LEN-1:0] rx_data,
  output logic               done
);

  localparam int IW = $clog2(MAX_LEN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [5:0]         len_q, len_d;
  logic               lsb_q, lsb_d;
  logic               tx_neg_q, tx_neg_d;
  logic               rx_neg_q, rx_neg_d;
  logic [MAX_LEN-1:0] tx_word_q, tx_word_d;
  logic [5:0]         tx_cnt_q, tx_cnt_d;
  logic [5:0]         rx_cnt_q, rx_cnt_d;
  logic [MAX_LEN-1:0] rx_sr_q, rx_sr_d;
  logic [MAX_LEN-1:0] rx_data_q, rx_data_d;
  logic               mosi_q, mosi_d;
  logic               tip_q, tip_d;
  logic               lstclk_q, lstclk_d;
  logic               done_q, done_d;

  logic               tx_stb;
  logic               rx_stb;
  logic [5:0]         new_len;
  logic [IW-1:0]      first_idx;
  logic [IW-1:0]      tx_idx;

  // Next-state, datapath and registered-output computation for the transfer FSM.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    lsb_d     = lsb_q;
    tx_neg_d  = tx_neg_q;
    rx_neg_d  = rx_neg_q;
    tx_word_d = tx_word_q;
    tx_cnt_d  = tx_cnt_q;
    rx_cnt_d  = rx_cnt_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    mosi_d    = mosi_q;

    // Strobe selection uses the configuration latched at go, never the live inputs.
    tx_stb    = tx_neg_q ? neg_edge : pos_edge;
    rx_stb    = rx_neg_q ? neg_edge : pos_edge;

    // A zero char_len means a full-width character.
    new_len   = (char_len == 5'd0) ? 6'(MAX_LEN) : {1'b0, char_len};
    first_idx = IW'(new_len - 6'd1);
    tx_idx    = lsb_q ? tx_cnt_q[IW-1:0] : IW'(len_q - 6'd1 - tx_cnt_q);

    case (state_q)
      IDLE: begin
        if (go) begin
          state_d   = SHIFT;
          len_d     = new_len;
          lsb_d     = lsb;
          tx_neg_d  = tx_negedge;
          rx_neg_d  = rx_negedge;
          tx_word_d = tx_data;
          tx_cnt_d  = 6'd1;
          rx_cnt_d  = 6'd0;
          rx_sr_d   = '0;
          mosi_d    = lsb ? tx_data[0] : tx_data[first_idx];
        end
      end
      SHIFT: begin
        // Launch: once every bit is out, mosi keeps the last one.
        if (tx_stb && (tx_cnt_q < len_q)) begin
          mosi_d   = tx_word_q[tx_idx];
          tx_cnt_d = tx_cnt_q + 6'd1;
        end
        // Capture: both orders end right-aligned in [len-1:0].
        if (rx_stb) begin
          if (lsb_q) begin
            rx_sr_d[rx_cnt_q[IW-1:0]] = miso;
          end else begin
            rx_sr_d = {rx_sr_q[MAX_LEN-2:0], miso};
          end
          rx_cnt_d = rx_cnt_q + 6'd1;
          if (rx_cnt_d == len_q) begin
            state_d   = FINISH;
            rx_data_d = rx_sr_d;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    tip_d    = (state_d == SHIFT);
    done_d   = (state_d == FINISH);
    lstclk_d = (state_d == SHIFT) && (rx_cnt_d == (len_d - 6'd1));
  end

  // State and registered outputs; reset clears everything, mid-transfer included.
  always_ff @(posedge wb_clk or posedge wb_reset) begin
    if (wb_reset) begin
      state_q   <= IDLE;
      len_q     <= 6'd0;
      lsb_q     <= 1'b0;
      tx_neg_q  <= 1'b0;
      rx_neg_q  <= 1'b0;
      tx_word_q <= '0;
      tx_cnt_q  <= 6'd0;
      rx_cnt_q  <= 6'd0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      mosi_q    <= 1'b0;
      tip_q     <= 1'b0;
      lstclk_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      lsb_q     <= lsb_d;
      tx_neg_q  <= tx_neg_d;
      rx_neg_q  <= rx_neg_d;
      tx_word_q <= tx_word_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      mosi_q    <= mosi_d;
      tip_q     <= tip_d;
      lstclk_q  <= lstclk_d;
      done_q    <= done_d;
    end
  end

  assign mosi    = mosi_q;
  assign tip     = tip_q;
  assign lstclk  = lstclk_q;
  assign rx_data = rx_data_q;
  assign done    = done_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: a bit-queue reference model, an every-cycle
// compare process, directed scenarios with literal expectations and a
// randomized phase with noisy configuration inputs.
module tb_spi_xfer_ctrl;

  // ---------------- clock / reset ----------------
  logic        wb_clk = 1'b0;
  logic        wb_reset = 1'b1;
  logic        go = 1'b0;
  logic [4:0]  char_len = 5'd0;
  logic [31:0] tx_data = 32'd0;
  logic        lsb = 1'b0;
  logic        tx_negedge = 1'b0;
  logic        rx_negedge = 1'b0;
  logic        pos_edge = 1'b0;
  logic        neg_edge = 1'b0;
  logic        miso_drv = 1'b0;
  logic        loop_en = 1'b0;
  logic        miso;
  logic        mosi;
  logic        tip;
  logic        lstclk;
  logic [31:0] rx_data;
  logic        done;

  always #5 wb_clk = ~wb_clk;

  assign miso = loop_en ? mosi : miso_drv;

  spi_xfer_ctrl #(.MAX_LEN(32)) dut (
    .wb_clk     (wb_clk),
    .wb_reset   (wb_reset),
    .go         (go),
    .char_len   (char_len),
    .tx_data    (tx_data),
    .lsb        (lsb),
    .tx_negedge (tx_negedge),
    .rx_negedge (rx_negedge),
    .pos_edge   (pos_edge),
    .neg_edge   (neg_edge),
    .miso       (miso),
    .mosi       (mosi),
    .tip        (tip),
    .lstclk     (lstclk),
    .rx_data    (rx_data),
    .done       (done)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int lst_cnt  = 0;
  bit chk_on   = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A transfer is a queue of bits still to send and a list of bits received;
  // the received word is assembled arithmetically when the list is full.
  int          m_phase = 0;   // 0 idle, 1 busy, 2 completion cycle
  int          m_len = 0;
  bit          m_lsb, m_txn, m_rxn, m_ts, m_rs;
  bit          tx_q[$];
  bit          rx_bits[$];
  logic        exp_mosi = 1'b0;
  logic        exp_tip = 1'b0;
  logic        exp_lstclk = 1'b0;
  logic        exp_done = 1'b0;
  logic [31:0] exp_rx = 32'd0;

  always @(posedge wb_clk or posedge wb_reset) begin
    if (wb_reset) begin
      m_phase = 0;
      tx_q.delete();
      rx_bits.delete();
      exp_mosi = 1'b0;
      exp_tip = 1'b0;
      exp_lstclk = 1'b0;
      exp_done = 1'b0;
      exp_rx = 32'd0;
    end else begin
      case (m_phase)
        0: begin
          exp_done = 1'b0;
          if (go) begin
            m_len = (char_len == 5'd0) ? 32 : int'(char_len);
            m_lsb = lsb;
            m_txn = tx_negedge;
            m_rxn = rx_negedge;
            tx_q.delete();
            rx_bits.delete();
            for (int k = 0; k < m_len; k++)
              tx_q.push_back(m_lsb ? tx_data[k] : tx_data[m_len-1-k]);
            exp_mosi = tx_q.pop_front();
            exp_tip = 1'b1;
            exp_lstclk = (m_len == 1);
            m_phase = 1;
          end
        end
        1: begin
          m_ts = m_txn ? neg_edge : pos_edge;
          m_rs = m_rxn ? neg_edge : pos_edge;
          if (m_rs) rx_bits.push_back(miso);
          if (m_ts && tx_q.size() > 0) exp_mosi = tx_q.pop_front();
          if (rx_bits.size() == m_len) begin
            exp_rx = 32'd0;
            for (int k = 0; k < m_len; k++) begin
              if (m_lsb) exp_rx[k] = rx_bits[k];
              else       exp_rx[m_len-1-k] = rx_bits[k];
            end
            exp_done = 1'b1;
            exp_tip = 1'b0;
            exp_lstclk = 1'b0;
            m_phase = 2;
          end else begin
            exp_lstclk = (rx_bits.size() == m_len - 1);
          end
        end
        default: begin
          exp_done = 1'b0;
          m_phase = 0;
        end
      endcase
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge wb_clk) begin
    if (done) done_cnt++;
    if (lstclk) lst_cnt++;
    if (chk_on) begin
      check("mosi", {31'd0, mosi}, {31'd0, exp_mosi});
      check("tip", {31'd0, tip}, {31'd0, exp_tip});
      check("lstclk", {31'd0, lstclk}, {31'd0, exp_lstclk});
      check("done", {31'd0, done}, {31'd0, exp_done});
      check("rx_data", rx_data, exp_rx);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic start(input logic [4:0] cl, input logic [31:0] txd,
                       input logic l, input logic tn, input logic rn);
    go = 1'b1;
    char_len = cl;
    tx_data = txd;
    lsb = l;
    tx_negedge = tn;
    rx_negedge = rn;
    tick();
    go = 1'b0;
  endtask

  task automatic pair();
    pos_edge = 1'b1;
    tick();
    pos_edge = 1'b0;
    neg_edge = 1'b1;
    tick();
    neg_edge = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] hist;
  int         cyc;

  initial begin
    repeat (2) tick();
    check("reset_mosi", {31'd0, mosi}, 32'd0);
    check("reset_tip", {31'd0, tip}, 32'd0);
    check("reset_lstclk", {31'd0, lstclk}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_rx_data", rx_data, 32'd0);
    wb_reset = 1'b0;
    chk_on = 1'b1;
    tick();

    // 8-bit MSB-first loopback, launch on neg, capture on pos.
    loop_en = 1'b1;
    done_cnt = 0;
    start(5'd8, 32'h0000_00A5, 1'b0, 1'b1, 1'b0);
    hist[7] = mosi;
    for (int i = 1; i < 8; i++) begin
      pair();
      hist[7-i] = mosi;
    end
    pair();
    tick();
    check("a5_mosi_seq", {24'd0, hist}, 32'h0000_00A5);
    check("a5_rx_data", rx_data, 32'h0000_00A5);
    check("a5_done_pulses", done_cnt, 32'd1);

    // Strobes while idle with no go.
    for (int i = 0; i < 6; i++) begin
      pos_edge = 1'($urandom_range(0, 1));
      neg_edge = 1'($urandom_range(0, 1));
      tick();
    end
    pos_edge = 1'b0;
    neg_edge = 1'b0;
    tick();
    check("idle_rx_data", rx_data, 32'h0000_00A5);
    check("idle_mosi", {31'd0, mosi}, 32'd1);
    check("idle_tip", {31'd0, tip}, 32'd0);
    check("idle_done_pulses", done_cnt, 32'd1);

    // 32-bit LSB-first loopback.
    done_cnt = 0;
    lst_cnt = 0;
    start(5'd0, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0);
    repeat (32) pair();
    tick();
    check("w32_rx_data", rx_data, 32'hDEAD_BEEF);
    check("w32_lstclk_cycles", lst_cnt, 32'd2);
    check("w32_done_pulses", done_cnt, 32'd1);

    // 4-bit LSB-first with miso held high.
    loop_en = 1'b0;
    miso_drv = 1'b1;
    start(5'd4, $urandom, 1'b1, 1'b0, 1'b0);
    repeat (4) pair();
    tick();
    check("ones4_rx_data", rx_data, 32'h0000_000F);

    // go and configuration changed mid-transfer.
    loop_en = 1'b1;
    done_cnt = 0;
    start(5'd8, 32'h0000_003C, 1'b0, 1'b1, 1'b0);
    pair();
    pair();
    go = 1'b1;
    char_len = 5'd3;
    tx_data = 32'hFFFF_FFFF;
    lsb = 1'b1;
    tx_negedge = 1'b0;
    rx_negedge = 1'b1;
    pair();
    go = 1'b0;
    repeat (5) pair();
    tick();
    check("noise_rx_data", rx_data, 32'h0000_003C);
    check("noise_done_pulses", done_cnt, 32'd1);

    // Reset after the third rx strobe.
    start(5'd8, 32'h0000_005A, 1'b0, 1'b1, 1'b0);
    repeat (3) pair();
    #2;
    wb_reset = 1'b1;
    #1;
    check("rst_tip", {31'd0, tip}, 32'd0);
    check("rst_lstclk", {31'd0, lstclk}, 32'd0);
    check("rst_mosi", {31'd0, mosi}, 32'd0);
    check("rst_rx_data", rx_data, 32'd0);
    tick();
    tick();
    wb_reset = 1'b0;
    repeat (2) pair();
    check("post_rst_tip", {31'd0, tip}, 32'd0);
    done_cnt = 0;
    start(5'd8, 32'h0000_0096, 1'b1, 1'b0, 1'b0);
    repeat (8) pair();
    tick();
    check("post_rst_rx_data", rx_data, 32'h0000_0096);
    check("post_rst_done_pulses", done_cnt, 32'd1);

    // Randomized transfers with noisy inputs while busy.
    for (int t = 0; t < 40; t++) begin
      loop_en = 1'($urandom_range(0, 1));
      pos_edge = 1'($urandom_range(0, 1));
      neg_edge = 1'($urandom_range(0, 1));
      start(5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      cyc = 0;
      while (m_phase != 0 && cyc < 1000) begin
        pos_edge = ($urandom_range(0, 2) == 0);
        neg_edge = ($urandom_range(0, 2) == 0);
        miso_drv = 1'($urandom_range(0, 1));
        go = ($urandom_range(0, 3) == 0);
        char_len = 5'($urandom_range(0, 31));
        tx_data = $urandom;
        lsb = 1'($urandom_range(0, 1));
        tx_negedge = 1'($urandom_range(0, 1));
        rx_negedge = 1'($urandom_range(0, 1));
        tick();
        cyc++;
      end
      go = 1'b0;
      if (cyc >= 1000) begin
        n_checks++;
        n_fail++;
        $display("FAIL rand_timeout: transfer %0d still busy after %0d cycles, required completion", t, cyc);
      end
      repeat ($urandom_range(0, 3)) begin
        pos_edge = 1'($urandom_range(0, 1));
        neg_edge = 1'($urandom_range(0, 1));
        tick();
      end
      pos_edge = 1'b0;
      neg_edge = 1'b0;
    end

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_xfer_ctrl.md
SPI_XFER_CTRL -- requirements
Module: spi_xfer_ctrl

Interface
REQ-001 SHALL have parameter MAX_LEN, default 32, maximum character length in bits; char_len width is 5 bits and tx_data/rx_data width is MAX_LEN.
REQ-002 SHALL have wb_clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have wb_reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have go  input  1  start request, sampled each cycle.
REQ-005 SHALL have char_len  input  5  transfer length in bits; 0 encodes 32 (MAX_LEN).
REQ-006 SHALL have tx_data  input  32  transmit word.
REQ-007 SHALL have lsb  input  1  1 = LSB first, 0 = MSB first.
REQ-008 SHALL have tx_negedge, rx_negedge  input  1 each  1 = launch/capture on neg_edge strobe, 0 = on pos_edge strobe.
REQ-009 SHALL have pos_edge, neg_edge  input  1 each  one-cycle SCLK edge strobes from the clock generator.
REQ-010 SHALL have miso  input  1  serial receive data.
REQ-011 SHALL have mosi  output  1  serial transmit data.
REQ-012 SHALL have tip  output  1  transfer in progress; enables the clock generator.
REQ-013 SHALL have lstclk  output  1  last SCLK cycle of the current transfer.
REQ-014 SHALL have rx_data  output  32  received word.
REQ-015 SHALL have done  output  1  one-cycle completion pulse.

Function
REQ-016 SHALL implement states IDLE, SHIFT, FINISH; reset state IDLE.
REQ-017 IDLE: go=1 SHALL latch char_len, lsb, tx_negedge, rx_negedge and tx_data, set len (0 -> 32), drive mosi with the first bit (tx_data[len-1] if lsb=0, else tx_data[0]), set tx_cnt=1, rx_cnt=0, and enter SHIFT with tip=1 on the next cycle.
REQ-018 Config inputs SHALL be ignored outside the go-accept cycle; changes mid-transfer have no effect.
REQ-019 SHIFT: each tx strobe (neg_edge if tx_negedge, else pos_edge) with tx_cnt<len SHALL drive the next bit onto mosi and increment tx_cnt; once tx_cnt=len, mosi holds the last bit.
REQ-020 SHIFT: each rx strobe SHALL shift miso into the receive register and increment rx_cnt. With lsb=0, bits enter at bit 0 and shift left. With lsb=1, the k-th received bit lands in bit k.
REQ-021 If a single strobe is both the tx and the rx strobe, SHALL perform capture and launch in the same cycle, each on its own counter.
REQ-022 lstclk SHALL be 1 exactly while in SHIFT with rx_cnt=len-1.
REQ-023 When rx_cnt reaches len, SHALL enter FINISH the next cycle. In FINISH: tip=0, done=1 for one cycle, rx_data loaded with the received word right-aligned in bits [len-1:0] with upper bits 0; then return to IDLE.
REQ-024 rx_data SHALL hold its value except at the FINISH load.
REQ-025 go SHALL be ignored in SHIFT and FINISH; no queuing.
REQ-026 pos_edge/neg_edge SHALL be ignored in IDLE and FINISH.
REQ-027 Both strobes asserted in the same cycle SHALL each be processed per REQ-019/020.
REQ-028 Counters SHALL be 6 bits wide and SHALL never wrap during a transfer.

Reset
REQ-029 wb_reset=1 SHALL immediately force IDLE, tip=0, lstclk=0, done=0, mosi=0, rx_data=0, and clear counters and shift registers, including mid-transfer.
REQ-030 After reset deassertion, SHALL require a new go to start; no partial-transfer state survives.

Verification
REQ-031 char_len=8, lsb=0, tx_negedge=1, rx_negedge=0, tx_data=0xA5, mosi looped to miso, 8 pos/neg strobe pairs -> mosi sequence 1,0,1,0,0,1,0,1; rx_data=0x000000A5; done pulses once; tip high throughout.
REQ-032 char_len=0, lsb=1, tx_data=0xDEADBEEF, loopback -> 32 bits sent LSB first; rx_data=0xDEADBEEF; lstclk high only during the 32nd rx strobe interval.
REQ-033 char_len=4, lsb=1, miso held 1 -> rx_data=0x0000000F; bits [31:4]=0.
REQ-034 go pulsed again mid-transfer and char_len changed mid-transfer -> transfer length and data unchanged; only one done pulse.
REQ-035 wb_reset asserted after the 3rd rx strobe -> tip, lstclk, mosi and rx_data go to 0 asynchronously; the next go starts a clean transfer.
REQ-036 Strobes applied in IDLE with no go -> mosi, rx_data and tip unchanged; no done pulse.
